// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage. Main/ALU decode, immediate extension, a
// register file with writeback bypass, and the ID/EX pipeline register.
module decode_cycle #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;

  logic            w_reg_write;
  logic [1:0]      w_imm_src;
  logic            w_alu_src;
  logic            w_mem_write;
  logic [1:0]      w_result_src;
  logic            w_branch;
  logic [1:0]      w_alu_op;
  logic            w_jump;
  logic [2:0]      w_alu_ctrl;
  logic [XLEN-1:0] w_imm_ext;

  logic            w_wb_hit;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;

  logic [XLEN-1:0] r_rf [NREG];

  logic            r_reg_write;
  logic [1:0]      r_result_src;
  logic            r_mem_write;
  logic            r_jump;
  logic            r_branch;
  logic            r_alu_src;
  logic [2:0]      r_alu_ctrl;
  logic [XLEN-1:0] r_rd1;
  logic [XLEN-1:0] r_rd2;
  logic [XLEN-1:0] r_imm_ext;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;

  assign w_opcode = InstrD[6:0];
  assign w_rd     = InstrD[11:7];
  assign w_funct3 = InstrD[14:12];
  assign w_rs1    = InstrD[19:15];
  assign w_rs2    = InstrD[24:20];

  // Unlisted opcodes fall through to all-zero controls, i.e. a bubble.
  always_comb begin
    w_reg_write  = 1'b0;
    w_imm_src    = 2'b00;
    w_alu_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_result_src = 2'b00;
    w_branch     = 1'b0;
    w_alu_op     = 2'b00;
    w_jump       = 1'b0;
    case (w_opcode)
      OP_LW: begin
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_result_src = 2'b01;
      end
      OP_SW: begin
        w_imm_src   = 2'b01;
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      OP_R: begin
        w_reg_write = 1'b1;
        w_alu_op    = 2'b10;
      end
      OP_I: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_op    = 2'b10;
      end
      OP_BEQ: begin
        w_imm_src = 2'b10;
        w_branch  = 1'b1;
        w_alu_op  = 2'b01;
      end
      OP_JAL: begin
        w_reg_write  = 1'b1;
        w_imm_src    = 2'b11;
        w_result_src = 2'b10;
        w_jump       = 1'b1;
      end
      default: ;
    endcase
  end

  // funct7[5] only selects sub for register-register ops; addi ignores it.
  always_comb begin
    w_alu_ctrl = ALU_ADD;
    case (w_alu_op)
      2'b01: w_alu_ctrl = ALU_SUB;
      2'b10: begin
        case (w_funct3)
          3'b000:  w_alu_ctrl = (w_opcode[5] & InstrD[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  w_alu_ctrl = ALU_SLT;
          3'b110:  w_alu_ctrl = ALU_OR;
          3'b111:  w_alu_ctrl = ALU_AND;
          default: w_alu_ctrl = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    w_imm_ext = '0;
    case (w_imm_src)
      2'b00: w_imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      2'b01: w_imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10: w_imm_ext = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                          InstrD[30:25], InstrD[11:8], 1'b0};
      2'b11: w_imm_ext = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                          InstrD[20], InstrD[30:21], 1'b0};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_wb_hit) begin
      r_rf[RDW] <= ResultW;
    end
  end

  // Writeback in the same cycle is forwarded so decode never sees stale data.
  assign w_wb_hit = RegWriteW && (RDW != 5'd0);
  assign w_rd1 = (w_rs1 == 5'd0) ? '0 :
                 (w_wb_hit && (RDW == w_rs1)) ? ResultW : r_rf[w_rs1];
  assign w_rd2 = (w_rs2 == 5'd0) ? '0 :
                 (w_wb_hit && (RDW == w_rs2)) ? ResultW : r_rf[w_rs2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write  <= 1'b0;
      r_result_src <= 2'b00;
      r_mem_write  <= 1'b0;
      r_jump       <= 1'b0;
      r_branch     <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_ctrl   <= 3'b000;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm_ext    <= '0;
      r_rs1        <= 5'd0;
      r_rs2        <= 5'd0;
      r_rd         <= 5'd0;
      r_pc         <= '0;
      r_pc_plus4   <= '0;
    end else if (FlushE) begin
      r_reg_write  <= 1'b0;
      r_result_src <= 2'b00;
      r_mem_write  <= 1'b0;
      r_jump       <= 1'b0;
      r_branch     <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_ctrl   <= 3'b000;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm_ext    <= '0;
      r_rs1        <= 5'd0;
      r_rs2        <= 5'd0;
      r_rd         <= 5'd0;
      r_pc         <= '0;
      r_pc_plus4   <= '0;
    end else begin
      r_reg_write  <= w_reg_write;
      r_result_src <= w_result_src;
      r_mem_write  <= w_mem_write;
      r_jump       <= w_jump;
      r_branch     <= w_branch;
      r_alu_src    <= w_alu_src;
      r_alu_ctrl   <= w_alu_ctrl;
      r_rd1        <= w_rd1;
      r_rd2        <= w_rd2;
      r_imm_ext    <= w_imm_ext;
      r_rs1        <= w_rs1;
      r_rs2        <= w_rs2;
      r_rd         <= w_rd;
      r_pc         <= PCD;
      r_pc_plus4   <= PCPlus4D;
    end
  end

  assign RegWriteE   = r_reg_write;
  assign ResultSrcE  = r_result_src;
  assign MemWriteE   = r_mem_write;
  assign JumpE       = r_jump;
  assign BranchE     = r_branch;
  assign ALUSrcE     = r_alu_src;
  assign ALUControlE = r_alu_ctrl;
  assign RD1E        = r_rd1;
  assign RD2E        = r_rd2;
  assign ImmExtE     = r_imm_ext;
  assign Rs1E        = r_rs1;
  assign Rs2E        = r_rs2;
  assign RdE         = r_rd;
  assign PCE         = r_pc;
  assign PCPlus4E    = r_pc_plus4;

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Second stage of the five-stage RV32I pipeline; sits directly downstream of the fetch stage and consumes its InstrD, PCD and PCPlus4D outputs.
- Contains the main decoder, ALU decoder, immediate extender and the 32x32 register file, whose write port is driven by the writeback stage.
- Ends in the ID/EX pipeline register that feeds the execute stage.

Parameters:
- XLEN, 32, datapath and register width.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- InstrD  input  32  instruction from the fetch stage
- PCD  input  32  PC of InstrD
- PCPlus4D  input  32  PCD+4
- RegWriteW  input  1  writeback register-write enable
- RDW  input  5  writeback destination register
- ResultW  input  32  writeback data
- FlushE  input  1  loads a bubble into the ID/EX register
- RegWriteE  output  1  register-write control to execute
- ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+4
- MemWriteE  output  1  store enable
- JumpE  output  1  jal
- BranchE  output  1  beq
- ALUSrcE  output  1  0 = RD2, 1 = immediate
- ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RD1E  output  32  rs1 data
- RD2E  output  32  rs2 data
- ImmExtE  output  32  sign-extended immediate
- Rs1E  output  5  rs1 index
- Rs2E  output  5  rs2 index
- RdE  output  5  rd index
- PCE  output  32  registered PCD
- PCPlus4E  output  32  registered PCPlus4D

Behaviour:
- Reset: while rst=0, all 32 registers and every ID/EX output are 0, asynchronously. Release is synchronous to the next rising edge.
- Latency: one cycle. Decode of InstrD captured on edge N appears on all E outputs after edge N.
- Register file:
  - Reads are combinational on InstrD[19:15] and InstrD[24:20].
  - Write happens at the rising edge when RegWriteW=1 and RDW!=0. Writes to x0 are ignored, and x0 always reads 0.
  - Bypass: if RegWriteW=1, RDW!=0 and RDW equals a read index in the same cycle, that read returns ResultW.
- Main decoder (opcode, gives RegWrite/ImmSrc/ALUSrc/MemWrite/ResultSrc/Branch/ALUOp/Jump):
  - lw 0000011: 1/00/1/0/01/0/00/0
  - sw 0100011: 0/01/1/1/00/0/00/0
  - R-type 0110011: 1/xx/0/0/00/0/10/0
  - I-ALU 0010011: 1/00/1/0/00/0/10/0
  - beq 1100011: 0/10/0/0/00/1/01/0
  - jal 1101111: 1/11/x/0/10/0/xx/1
  - Any other opcode: all controls 0 (bubble).
- ALU decoder:
  - ALUOp 00 gives add; ALUOp 01 gives sub.
  - ALUOp 10 decodes funct3:
    - 000: sub when opcode[5]&funct7[5]=1, otherwise add
    - 010: slt
    - 110: or
    - 111: and
    - any other funct3: add
- Immediate extender:
  - I: {20{i[31]}, i[31:20]}
  - S: {20{i[31]}, i[31:25], i[11:7]}
  - B: {19{i[31]}, i[31], i[7], i[30:25], i[11:8], 0}
  - J: {11{i[31]}, i[31], i[19:12], i[20], i[30:21], 0}
- Flush: when FlushE=1 at an edge, the entire ID/EX register loads 0. The register-file write that edge still occurs.
- Simultaneous reset and flush: reset wins. Reset mid-operation clears the register-file contents.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> all E outputs 0. After release, InstrD=0x000281B3 -> RD1E=0.
- Write then read: RegWriteW=1, RDW=5, ResultW=0x000000AA for one edge, then InstrD=0x000281B3 (add x3,x5,x0) -> RD1E=0xAA, RD2E=0, RdE=3, Rs1E=5, ALUControlE=000, RegWriteE=1, ALUSrcE=0.
- x0 protection: RegWriteW=1, RDW=0, ResultW=0xFFFFFFFF, then read x0 -> RD1E=0.
- Same-cycle bypass: RegWriteW=1, RDW=5, ResultW=0x00001234 with InstrD=0x000281B3 -> RD1E=0x00001234 after that edge.
- Immediate/control: InstrD=0xFFC12083 (lw x1,-4(x2)) -> ImmExtE=0xFFFFFFFC, ResultSrcE=01, ALUSrcE=1, RegWriteE=1, RdE=1.
- Flush: InstrD=0x000281B3, PCD=0x10 with FlushE=1 -> all E outputs 0 including PCE. The next edge with FlushE=0 -> PCE=0x10.
